mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Two requester ports plus the shared memory port of mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  logic        r0_req;
  logic        r1_req;
  logic        r0_we;
  logic        r1_we;
  logic [2:0]  r0_funct3;
  logic [2:0]  r1_funct3;
  logic [31:0] r0_addr;
  logic [31:0] r1_addr;
  logic [31:0] r0_wdata;
  logic [31:0] r1_wdata;
  logic        r0_gnt;
  logic        r1_gnt;
  logic        r0_rvalid;
  logic        r1_rvalid;
  logic [31:0] r0_rdata;
  logic [31:0] r1_rdata;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;

  // Arbiter side
  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_funct3, r1_funct3,
           r0_addr, r1_addr, r0_wdata, r1_wdata, read_data,
    output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
           write_mem, funct3, write_address, write_data, read_address
  );

  // Requesters and memory side
  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_funct3, r1_funct3,
           r0_addr, r1_addr, r0_wdata, r1_wdata, read_data,
    input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
           write_mem, funct3, write_address, write_data, read_address
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter onto one memory port with load routing
//               and a saturating conflict counter. Define MEM_ARBITER_RR_EN
//               for round-robin tie breaking (default: requester 0 priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] conflict_cnt
);

`ifdef MEM_ARBITER_RR_EN
  localparam logic c_RR_EN = 1'b1;
`else
  localparam logic c_RR_EN = 1'b0;
`endif

  logic             r_pending;
  logic             r_owner;
  logic             r_last_winner;
  logic [CNT_W-1:0] r_conflict_cnt;

  logic w_both;
  logic w_tie_r1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;
  logic w_sel_we;

  assign w_both    = bus.r0_req & bus.r1_req;
  // In round-robin mode the requester that did not win last takes the tie
  assign w_tie_r1  = c_RR_EN & ~r_last_winner;
  assign w_gnt1    = bus.r1_req & (~bus.r0_req | w_tie_r1);
  assign w_gnt0    = bus.r0_req & ~w_gnt1;
  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign w_sel_we  = w_gnt1 ? bus.r1_we : bus.r0_we;

  assign bus.r0_gnt = w_gnt0;
  assign bus.r1_gnt = w_gnt1;

  always_comb begin
    bus.write_mem     = 1'b0;
    bus.funct3        = 3'b000;
    bus.write_address = 32'h0;
    bus.write_data    = 32'h0;
    bus.read_address  = 32'h0;
    if (w_gnt0) begin
      bus.write_mem     = bus.r0_we;
      bus.funct3        = bus.r0_funct3;
      bus.write_address = bus.r0_addr;
      bus.write_data    = bus.r0_wdata;
      bus.read_address  = bus.r0_addr;
    end else if (w_gnt1) begin
      bus.write_mem     = bus.r1_we;
      bus.funct3        = bus.r1_funct3;
      bus.write_address = bus.r1_addr;
      bus.write_data    = bus.r1_wdata;
      bus.read_address  = bus.r1_addr;
    end
  end

  // Owner and pending are re-captured every edge so back-to-back loads route correctly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= 1'b0;
      r_owner       <= 1'b0;
      r_last_winner <= 1'b1;
    end else begin
      r_pending <= w_any_gnt & ~w_sel_we;
      if (w_any_gnt) begin
        r_owner       <= w_gnt1;
        r_last_winner <= w_gnt1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign conflict_cnt  = r_conflict_cnt;
  assign bus.r0_rvalid = r_pending & ~r_owner;
  assign bus.r1_rvalid = r_pending &  r_owner;
  assign bus.r0_rdata  = bus.r0_rvalid ? bus.read_data : 32'h0;
  assign bus.r1_rdata  = bus.r1_rvalid ? bus.read_data : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a load-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  localparam int c_CNT_W = 3;
`ifdef MEM_ARBITER_RR_EN
  localparam bit c_RR = 1'b1;
`else
  localparam bit c_RR = 1'b0;
`endif

  typedef struct {
    bit          port;
    logic [31:0] data;
  } sb_entry_t;

  logic               clk;
  logic               rst_n;
  logic [c_CNT_W-1:0] conflict_cnt;
  int                 n_checks;
  int                 n_errors;
  sb_entry_t          sb[$];
  bit                 model_last;

  mem_arbiter_if bus ();

  mem_arbiter #(.CNT_W(c_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  // Memory returns data one cycle after the address is presented
  always @(posedge clk) bus.read_data <= mem_f(bus.read_address);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected load
  always @(negedge clk) begin
    sb_entry_t e;
    if (bus.r0_rvalid && bus.r1_rvalid) begin
      check_eq("both_rvalid", 32'd1, 32'd0);
    end else if (bus.r0_rvalid || bus.r1_rvalid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rvalid_port", {31'd0, bus.r1_rvalid}, {31'd0, e.port});
        check_eq("rdata", bus.r1_rvalid ? bus.r1_rdata : bus.r0_rdata, e.data);
        check_eq("other_rdata", bus.r1_rvalid ? bus.r0_rdata : bus.r1_rdata, 32'h0);
      end
    end else begin
      check_eq("idle_rdata", bus.r0_rdata | bus.r1_rdata, 32'h0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_funct3 = 3'b000;
    bus.r0_addr = 32'h0; bus.r0_wdata = 32'h0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_funct3 = 3'b000;
    bus.r1_addr = 32'h0; bus.r1_wdata = 32'h0;
  endtask

  task automatic drive_req(input bit port, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 1'b0) begin
      bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_funct3 = f3;
      bus.r0_addr = addr; bus.r0_wdata = wdata;
    end else begin
      bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_funct3 = f3;
      bus.r1_addr = addr; bus.r1_wdata = wdata;
    end
  endtask

  initial begin
    bit exp1;
    n_checks   = 0;
    n_errors   = 0;
    model_last = 1'b1;
    rst_n      = 1'b0;
    drive_idle();
    @(negedge clk);
    check_eq("rst_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
    check_eq("rst_cnt", {29'd0, conflict_cnt}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single load from r0
    drive_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    check_eq("load_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd1);
    check_eq("load_raddr", bus.read_address, 32'h10);
    check_eq("load_wmem", {31'd0, bus.write_mem}, 32'd0);
    check_eq("load_f3", {29'd0, bus.funct3}, 32'd2);
    sb.push_back('{1'b0, mem_f(32'h10)});
    next_cycle();
    drive_idle();
    @(negedge clk);
    check_eq("load_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd1);
    next_cycle();

    // Store from r1
    drive_req(1'b1, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("st_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd2);
    check_eq("st_wmem", {31'd0, bus.write_mem}, 32'd1);
    check_eq("st_waddr", bus.write_address, 32'h20);
    check_eq("st_wdata", bus.write_data, 32'hDEADBEEF);
    check_eq("st_f3", {29'd0, bus.funct3}, 32'd2);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check_eq("st_after_wmem", {31'd0, bus.write_mem}, 32'd0);
    check_eq("st_after_wdata", bus.write_data, 32'h0);
    check_eq("st_no_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
    next_cycle();

    // Tie held for four cycles, then r0 drops
    drive_req(1'b0, 1'b0, 3'b010, 32'h30, 32'h0);
    drive_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp1 = c_RR ? (i % 2 == 1) : 1'b0;
      @(negedge clk);
      check_eq("tie_cnt", {29'd0, conflict_cnt}, i);
      check_eq("tie_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, exp1 ? 32'd2 : 32'd1);
      sb.push_back('{exp1, mem_f(exp1 ? 32'h40 : 32'h30)});
      next_cycle();
    end
    bus.r0_req = 1'b0;
    @(negedge clk);
    check_eq("tie_release_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd2);
    check_eq("tie_cnt_final", {29'd0, conflict_cnt}, 32'd4);
    sb.push_back('{1'b1, mem_f(32'h40)});
    next_cycle();
    drive_idle();
    next_cycle();

    // Back-to-back loads r0 then r1
    drive_req(1'b0, 1'b0, 3'b100, 32'h50, 32'h0);
    @(negedge clk);
    sb.push_back('{1'b0, mem_f(32'h50)});
    next_cycle();
    drive_idle();
    drive_req(1'b1, 1'b0, 3'b000, 32'h60, 32'h0);
    @(negedge clk);
    check_eq("b2b_r0_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd1);
    check_eq("b2b_r1_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd2);
    sb.push_back('{1'b1, mem_f(32'h60)});
    next_cycle();
    drive_idle();
    @(negedge clk);
    check_eq("b2b_r1_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd2);
    next_cycle();

    // Reset right after a load grant drops its response
    drive_req(1'b0, 1'b0, 3'b010, 32'h70, 32'h0);
    @(negedge clk);
    check_eq("rst_load_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd1);
    next_cycle();
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    check_eq("rst_drop_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
    check_eq("rst_drop_cnt", {29'd0, conflict_cnt}, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
    next_cycle();

    // First tie after reset goes to r0; hold ties long enough to saturate the counter
    model_last = 1'b1;
    drive_req(1'b0, 1'b0, 3'b010, 32'h80, 32'h0);
    drive_req(1'b1, 1'b0, 3'b010, 32'h90, 32'h0);
    for (int i = 0; i < 10; i++) begin
      exp1 = c_RR ? ~model_last : 1'b0;
      @(negedge clk);
      if (i == 0) check_eq("post_rst_tie_r0", {31'd0, bus.r0_gnt}, 32'd1);
      check_eq("sat_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, exp1 ? 32'd2 : 32'd1);
      check_eq("sat_cnt", {29'd0, conflict_cnt}, (i > 7) ? 32'd7 : i);
      sb.push_back('{exp1, mem_f(exp1 ? 32'h90 : 32'h80)});
      model_last = exp1;
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    check_eq("sat_cnt_final", {29'd0, conflict_cnt}, 32'd7);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
